conv_window_scheduler: RTL

Sequences the shared image memory read unit over every kernel-window position of an IMAGE_WIDTH x IMAGE_HEIGHT image. Each batch assigns up to NUM_UNITS consecutive windows (row-major) to the parallel read lanes. For each batch the scheduler reloads the lane start addresses, issues K*K read steps, and tags the resulting tap stream for the downstream MAC array. It then handshakes a batch-complete token before moving to the next batch.

---
 rtl/conv_window_scheduler_if.sv | 46 ++++
 rtl/conv_window_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler_if.sv
// Bundle between conv_window_scheduler (master) and its host / memory unit / MAC array (slave).
// Optional build macro CONV_STRIDE_EN adds the stride input.
interface conv_window_scheduler_if #(
   parameter int IMAGE_WIDTH  = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int NUM_UNITS    = 2
);
   localparam int ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT);
   localparam int KW     = $clog2(IMAGE_WIDTH);

   logic                             start;
   logic [KW-1:0]                    kernel_dim;
`ifdef CONV_STRIDE_EN
   logic [KW-1:0]                    stride;
`endif
   logic                             mem_reset;
   logic                             mem_en;
   logic                             mem_step;
   logic [NUM_UNITS-1:0][ADDR_W-1:0] start_addr;
   logic [NUM_UNITS-1:0]             unit_valid;
   logic                             mac_valid;
   logic                             mac_last;
   logic                             batch_valid;
   logic                             batch_ready;
   logic                             busy;
   logic                             done;
   logic                             error;

   modport master (
`ifdef CONV_STRIDE_EN
      input  stride,
`endif
      input  start, kernel_dim, batch_ready,
      output mem_reset, mem_en, mem_step, start_addr, unit_valid,
      output mac_valid, mac_last, batch_valid, busy, done, error
   );

   modport slave (
`ifdef CONV_STRIDE_EN
      output stride,
`endif
      output start, kernel_dim, batch_ready,
      input  mem_reset, mem_en, mem_step, start_addr, unit_valid,
      input  mac_valid, mac_last, batch_valid, busy, done, error
   );
endinterface

// File: rtl/conv_window_scheduler.sv
// Walks every KxK window origin of the image in row-major batches of NUM_UNITS lanes and drives
// the shared memory read unit / MAC tap stream. Optional build macro CONV_STRIDE_EN enables a stride input.
module conv_window_scheduler #(
   parameter int IMAGE_WIDTH  = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int NUM_UNITS    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   conv_window_scheduler_if.master   bus
);
   localparam int ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT);
   localparam int KW     = $clog2(IMAGE_WIDTH);
   localparam int CW     = $clog2(2*IMAGE_WIDTH + 2*IMAGE_HEIGHT) + 1;
   localparam int KMAX   = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, WAIT_ACK} state_t;

   state_t                           state_q;
   logic [KW-1:0]                    k_q;
   logic [2*KW-1:0]                  kk_last_q;
   logic [2*KW-1:0]                  tap_q;
   logic [CW-1:0]                    row_q, col_q;
   logic [ADDR_W-1:0]                rbase_q;
   logic                             more_q;
   logic                             mem_reset_q, mem_en_q, mem_step_q;
   logic [NUM_UNITS-1:0][ADDR_W-1:0] start_addr_q;
   logic [NUM_UNITS-1:0]             unit_valid_q;
   logic                             mac_valid_q, mac_last_q;
   logic                             batch_valid_q, busy_q, done_q, error_q;

   logic [KW-1:0]                    k_eff, s_eff;
   logic [CW-1:0]                    k_w, s_w;
   logic [ADDR_W-1:0]                row_step;
   logic                             start_legal;
   logic                             do_load;

   // While IDLE the chain looks at the live inputs so the first batch loads on the accepting edge.
   assign k_eff = (state_q == IDLE) ? bus.kernel_dim : k_q;

`ifdef CONV_STRIDE_EN
   logic [KW-1:0] s_q;
   assign s_eff       = (state_q == IDLE) ? bus.stride : s_q;
   assign start_legal = (bus.kernel_dim != '0) && (CW'(bus.kernel_dim) <= CW'(KMAX)) &&
                        (bus.stride != '0);
`else
   assign s_eff       = KW'(1);
   assign start_legal = (bus.kernel_dim != '0) && (CW'(bus.kernel_dim) <= CW'(KMAX));
`endif

   assign k_w      = CW'(k_eff);
   assign s_w      = CW'(s_eff);
   assign row_step = ADDR_W'(s_eff * IMAGE_WIDTH);

   // Successor chain: entry 0 is the cursor, entry NUM_UNITS is the next batch's cursor.
   logic [CW-1:0]                    lane_row [NUM_UNITS+1];
   logic [CW-1:0]                    lane_col [NUM_UNITS+1];
   logic [ADDR_W-1:0]                lane_rb  [NUM_UNITS+1];
   logic [NUM_UNITS:0]               lane_v;
   logic [NUM_UNITS-1:0][ADDR_W-1:0] lane_addr;

   assign lane_row[0] = row_q;
   assign lane_col[0] = col_q;
   assign lane_rb[0]  = rbase_q;
   assign lane_v[0]   = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_lane
         logic col_fits, row_fits;
         assign col_fits       = (lane_col[gi] + s_w + k_w) <= CW'(IMAGE_WIDTH);
         assign row_fits       = (lane_row[gi] + s_w + k_w) <= CW'(IMAGE_HEIGHT);
         assign lane_v[gi+1]   = lane_v[gi] & (col_fits | row_fits);
         assign lane_col[gi+1] = col_fits ? lane_col[gi] + s_w : '0;
         assign lane_row[gi+1] = col_fits ? lane_row[gi] : lane_row[gi] + s_w;
         assign lane_rb[gi+1]  = col_fits ? lane_rb[gi] : lane_rb[gi] + row_step;
         assign lane_addr[gi]  = lane_v[gi] ? lane_rb[gi] + ADDR_W'(lane_col[gi]) : '0;
      end
   endgenerate

   assign do_load = ((state_q == IDLE) && bus.start && start_legal) ||
                    ((state_q == WAIT_ACK) && bus.batch_ready && more_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         k_q           <= '0;
         kk_last_q     <= '0;
         tap_q         <= '0;
         row_q         <= '0;
         col_q         <= '0;
         rbase_q       <= '0;
         more_q        <= 1'b0;
         mem_reset_q   <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_step_q    <= 1'b0;
         start_addr_q  <= '0;
         unit_valid_q  <= '0;
         mac_valid_q   <= 1'b0;
         mac_last_q    <= 1'b0;
         batch_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
`ifdef CONV_STRIDE_EN
         s_q           <= '0;
`endif
      end else begin
         mem_reset_q <= 1'b0;
         done_q      <= 1'b0;
         mac_valid_q <= mem_en_q;
         mac_last_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  error_q <= !start_legal;
                  if (start_legal) begin
                     k_q       <= bus.kernel_dim;
                     kk_last_q <= (2*KW)'(bus.kernel_dim) * (2*KW)'(bus.kernel_dim) - (2*KW)'(1);
`ifdef CONV_STRIDE_EN
                     s_q       <= bus.stride;
`endif
                     busy_q    <= 1'b1;
                     state_q   <= LOAD;
                  end
               end
            end
            LOAD: begin
               mem_en_q   <= 1'b1;
               mem_step_q <= 1'b1;
               tap_q      <= '0;
               state_q    <= RUN;
            end
            RUN: begin
               if (tap_q == kk_last_q) begin
                  mem_en_q   <= 1'b0;
                  mem_step_q <= 1'b0;
                  mac_last_q <= 1'b1;
                  state_q    <= FLUSH;
               end else begin
                  tap_q <= tap_q + (2*KW)'(1);
               end
            end
            FLUSH: begin
               batch_valid_q <= 1'b1;
               state_q       <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (bus.batch_ready) begin
                  batch_valid_q <= 1'b0;
                  if (more_q) begin
                     state_q <= LOAD;
                  end else begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     row_q   <= '0;
                     col_q   <= '0;
                     rbase_q <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         if (do_load) begin
            mem_reset_q  <= 1'b1;
            start_addr_q <= lane_addr;
            unit_valid_q <= lane_v[NUM_UNITS-1:0];
            row_q        <= lane_row[NUM_UNITS];
            col_q        <= lane_col[NUM_UNITS];
            rbase_q      <= lane_rb[NUM_UNITS];
            more_q       <= lane_v[NUM_UNITS];
         end
      end
   end

   assign bus.mem_reset   = mem_reset_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_step    = mem_step_q;
   assign bus.start_addr  = start_addr_q;
   assign bus.unit_valid  = unit_valid_q;
   assign bus.mac_valid   = mac_valid_q;
   assign bus.mac_last    = mac_last_q;
   assign bus.batch_valid = batch_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.error       = error_q;
endmodule
